// File: rtl/speed_dash_sequencer.sv
`timescale 1ns/1ps
// speed_dash_sequencer: converts a speed sample into a lit-dash target by scanning one threshold
// per clock, then ramps the lit-dash count toward that target paced by the frame animate strobe.
//   state  | meaning
//   S_IDLE | waiting for a speed sample
//   S_SCAN | comparing one dash threshold per clock to build the target
//   S_RAMP | stepping the lit count toward the target on animate pulses
module speed_dash_sequencer #(
    parameter int SPEED_W    = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_animate,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_speed_valid,
    output logic               o_speed_ready,
    output logic [5:0]         o_lit_count,
    output logic [32:0]        o_lit_mask,
    output logic [5:0]         o_target_count,
    output logic               o_go_animate,
    output logic               o_busy
);
    localparam int NUM_DASHES = 33;
    localparam int MAX_MPH    = 85;
    localparam int HOLD_W     = $clog2(HOLD_TICKS + 1);
    localparam logic [5:0] STEP_V   = 6'(STEP);
    localparam logic [5:0] LAST_IDX = 6'(NUM_DASHES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RAMP} state_t;

    state_t              state_q, state_d;
    logic [6:0]          speed_q, speed_d;
    logic [5:0]          idx_q, idx_d;
    logic [5:0]          target_q, target_d;
    logic [5:0]          lit_q, lit_d;
    logic [32:0]         mask_q, mask_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [HOLD_W-1:0]   hold_inc;
    logic                capture;

    // Dashes run 5, 7, then repeat the +0/+3/+5/+7 pattern every 10 mph from 10 mph.
    function automatic logic [6:0] thr(input logic [5:0] k);
        logic [5:0] j;
        logic [6:0] base;
        logic [6:0] off;
        if (k == 6'd0) return 7'd5;
        if (k == 6'd1) return 7'd7;
        j    = k - 6'd2;
        base = 7'(10 * (int'(j[5:2]) + 1));
        case (j[1:0])
            2'd0:    off = 7'd0;
            2'd1:    off = 7'd3;
            2'd2:    off = 7'd5;
            default: off = 7'd7;
        endcase
        return base + off;
    endfunction

    function automatic logic [5:0] step_toward(input logic [5:0] lit, input logic [5:0] tgt);
        if (lit < tgt)      return ((tgt - lit) <= STEP_V) ? tgt : lit + STEP_V;
        else if (lit > tgt) return ((lit - tgt) <= STEP_V) ? tgt : lit - STEP_V;
        else                return lit;
    endfunction

    assign capture  = i_speed_valid && (state_q != S_SCAN);
    assign hold_inc = hold_q + HOLD_W'(1);

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        idx_d    = idx_q;
        target_d = target_q;
        lit_d    = lit_q;
        hold_d   = hold_q;
        mask_d   = '0;
        case (state_q)
            S_SCAN: begin
                if (thr(idx_q) <= speed_q) begin
                    target_d = idx_q + 6'd1;
                    idx_d    = idx_q + 6'd1;
                    if (idx_q == LAST_IDX) state_d = S_RAMP;
                end else begin
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (lit_q == target_q) begin
                    if (!capture) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end
                end else if (i_animate) begin
                    if (hold_inc == HOLD_W'(HOLD_TICKS)) begin
                        hold_d = '0;
                        lit_d  = step_toward(lit_q, target_q);
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            default: ;
        endcase
        // A retarget keeps lit and hold progress; only the scan restarts.
        if (capture) begin
            speed_d  = (i_speed > SPEED_W'(MAX_MPH)) ? 7'(MAX_MPH) : 7'(i_speed);
            idx_d    = '0;
            target_d = '0;
            state_d  = S_SCAN;
        end
        for (int k = 0; k < NUM_DASHES; k++) mask_d[k] = (6'(k) < lit_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            speed_q  <= '0;
            idx_q    <= '0;
            target_q <= '0;
            lit_q    <= '0;
            mask_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            lit_q    <= lit_d;
            mask_q   <= mask_d;
            hold_q   <= hold_d;
        end
    end

    assign o_speed_ready  = (state_q != S_SCAN);
    assign o_lit_count    = lit_q;
    assign o_lit_mask     = mask_q;
    assign o_target_count = target_q;
    assign o_go_animate   = (state_q == S_RAMP);
    assign o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_speed_dash_sequencer.sv
`timescale 1ns/1ps
// Bench for speed_dash_sequencer: a STEP=1/HOLD=1 instance driven from a vector table and a
// STEP=4/HOLD=2 instance driven by hand for clamped steps, hold counting and mid-ramp retargets.
module tb_speed_dash_sequencer;
    logic        clk;
    logic        rst_n;
    logic        anim  [2];
    logic [7:0]  spd   [2];
    logic        vld   [2];
    logic        rdy   [2];
    logic [5:0]  lit   [2];
    logic [32:0] mask  [2];
    logic [5:0]  tgt   [2];
    logic        go    [2];
    logic        busy  [2];

    int total = 0;
    int bad   = 0;

    speed_dash_sequencer #(.SPEED_W(8), .STEP(1), .HOLD_TICKS(1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_animate(anim[0]), .i_speed(spd[0]),
        .i_speed_valid(vld[0]), .o_speed_ready(rdy[0]), .o_lit_count(lit[0]),
        .o_lit_mask(mask[0]), .o_target_count(tgt[0]), .o_go_animate(go[0]), .o_busy(busy[0])
    );

    speed_dash_sequencer #(.SPEED_W(8), .STEP(4), .HOLD_TICKS(2)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_animate(anim[1]), .i_speed(spd[1]),
        .i_speed_valid(vld[1]), .o_speed_ready(rdy[1]), .o_lit_count(lit[1]),
        .o_lit_mask(mask[1]), .o_target_count(tgt[1]), .o_go_animate(go[1]), .o_busy(busy[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  speed;
        int          target;
        int          lat;
        logic [32:0] mask;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge; the step (if any) is visible on return.
    task automatic pulse(input int d);
        anim[d] = 1'b1;
        @(negedge clk);
        anim[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic capture(input int d, input logic [7:0] s, input bit with_pulse,
                           input int exp_t, input int exp_lat);
        int lat;
        chk("ready_before_capture", 64'(rdy[d]), 64'(1));
        spd[d]  = s;
        vld[d]  = 1'b1;
        anim[d] = with_pulse;
        @(negedge clk);
        vld[d]  = 1'b0;
        anim[d] = 1'b0;
        chk("scan_entered", 64'(rdy[d]), 64'(0));
        lat = 1;
        while (!rdy[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("scan_latency", 64'(lat - 1), 64'(exp_lat));
        chk("target", 64'(tgt[d]), 64'(exp_t));
    endtask

    task automatic ramp(input int d, input int from, input int to, input logic [32:0] exp_mask);
        int n;
        int w;
        int exp_lit;
        n = (to > from) ? to - from : from - to;
        for (int p = 1; p <= n; p++) begin
            pulse(d);
            exp_lit = (to > from) ? from + p : from - p;
            chk("lit_step", 64'(lit[d]), 64'(exp_lit));
            if (p < n) chk("still_ramping", 64'(go[d]), 64'(1));
        end
        w = 0;
        while (busy[d] && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("back_to_idle", 64'(busy[d]), 64'(0));
        chk("final_lit", 64'(lit[d]), 64'(to));
        chk("final_mask", 64'(mask[d]), 64'(exp_mask));
        chk("idle_ready", 64'(rdy[d]), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int prev;
        clk   = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            anim[d] = 1'b0;
            spd[d]  = '0;
            vld[d]  = 1'b0;
        end

        vecs[0] = '{8'd0,   0,  1, 33'h0_0000_0000};
        vecs[1] = '{8'd40,  15, 16, 33'h0_0000_7FFF};
        vecs[2] = '{8'd12,  3,  4, 33'h0_0000_0007};
        vecs[3] = '{8'd200, 33, 33, 33'h1_FFFF_FFFF};
        vecs[4] = '{8'd5,   1,  2, 33'h0_0000_0001};
        vecs[5] = '{8'd4,   0,  1, 33'h0_0000_0000};
        vecs[6] = '{8'd85,  33, 33, 33'h1_FFFF_FFFF};
        vecs[7] = '{8'd84,  32, 33, 33'h0_FFFF_FFFF};
        vecs[8] = '{8'd6,   1,  2, 33'h0_0000_0001};
        vecs[9] = '{8'd7,   2,  3, 33'h0_0000_0003};

        #3;
        chk("rst_lit", 64'(lit[0]), 64'(0));
        chk("rst_mask", 64'(mask[0]), 64'(0));
        chk("rst_target", 64'(tgt[0]), 64'(0));
        chk("rst_busy", 64'(busy[0]), 64'(0));
        chk("rst_go", 64'(go[0]), 64'(0));
        chk("rst_ready", 64'(rdy[0]), 64'(1));
        #9 rst_n = 1'b1;
        @(negedge clk);

        prev = 0;
        for (int i = 0; i < 10; i++) begin
            capture(0, vecs[i].speed, 1'b0, vecs[i].target, vecs[i].lat);
            ramp(0, prev, vecs[i].target, vecs[i].mask);
            prev = vecs[i].target;
        end

        // STEP=4, HOLD=2: steps land on every second pulse and clamp at the target.
        capture(1, 8'd20, 1'b0, 7, 8);
        pulse(1); chk("b_hold_p1", 64'(lit[1]), 64'(0));
        pulse(1); chk("b_step_p2", 64'(lit[1]), 64'(4));
        pulse(1); chk("b_hold_p3", 64'(lit[1]), 64'(4));
        pulse(1); chk("b_clamp_p4", 64'(lit[1]), 64'(7));
        @(negedge clk);
        chk("b_idle", 64'(busy[1]), 64'(0));
        chk("b_mask7", 64'(mask[1]), 64'(33'h7F));

        capture(1, 8'd40, 1'b0, 15, 16);
        pulse(1);
        pulse(1); chk("b_lit11", 64'(lit[1]), 64'(11));
        pulse(1); chk("b_hold_before_retarget", 64'(lit[1]), 64'(11));
        capture(1, 8'd85, 1'b1, 33, 33);
        chk("b_step_with_capture", 64'(lit[1]), 64'(15));
        chk("b_mask_with_capture", 64'(mask[1]), 64'(33'h7FFF));
        pulse(1); chk("b_resume_hold", 64'(lit[1]), 64'(15));
        pulse(1); chk("b_resume_up", 64'(lit[1]), 64'(19));
        pulse(1);
        capture(1, 8'd85, 1'b0, 33, 33);
        pulse(1); chk("b_hold_kept_over_retarget", 64'(lit[1]), 64'(23));

        capture(0, 8'd85, 1'b0, 33, 33);
        pulse(0); pulse(0); pulse(0);
        chk("a_lit_before_reset", 64'(lit[0]), 64'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lit", 64'(lit[0]), 64'(0));
        chk("arst_mask", 64'(mask[0]), 64'(0));
        chk("arst_target", 64'(tgt[0]), 64'(0));
        chk("arst_go", 64'(go[0]), 64'(0));
        chk("arst_busy", 64'(busy[0]), 64'(0));
        chk("arst_ready", 64'(rdy[0]), 64'(1));
        chk("arst_b_busy", 64'(busy[1]), 64'(0));
        chk("arst_b_lit", 64'(lit[1]), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        capture(0, 8'd10, 1'b0, 3, 4);
        ramp(0, 0, 3, 33'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
